up_down_sequence_decoder: RTL and testbench

Receive-side companion to `up_down_counter`: observes an 8-bit count stream and recovers the direction and step size that produced it. Locks after a run of consistent steps, predicts each next value, and flags any sample that breaks the sequence. Sits on the monitoring/receiving end of any link that carries counter output. Also serves as a self-checking sink in counter benches.

---
 rtl/up_down_pkg.sv | 38 +++
 rtl/updn_step_classifier.sv | 28 ++
 rtl/up_down_sequence_decoder.sv | 142 ++++++++++++++
 tb/tb_up_down_sequence_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_pkg.sv
// Shared types, constants and step helpers for the up/down count-stream decoder.
package up_down_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned RUN_W  = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] STEP_1 = 8'd1;
    localparam logic [DATA_W-1:0] STEP_2 = 8'd2;
    localparam logic [DATA_W-1:0] STEP_4 = 8'd4;
    localparam logic [DATA_W-1:0] STEP_8 = 8'd8;

    function automatic logic [DATA_W-1:0] step_of(input logic [SEL_W-1:0] s);
        logic [DATA_W-1:0] r;
        case (s)
            2'd0:    r = STEP_1;
            2'd1:    r = STEP_2;
            2'd2:    r = STEP_4;
            default: r = STEP_8;
        endcase
        return r;
    endfunction

    // Modular prediction of the value that follows v for a given direction/step.
    function automatic logic [DATA_W-1:0] next_of(input logic [DATA_W-1:0] v,
                                                   input logic              dir,
                                                   input logic [SEL_W-1:0]  s);
        return dir ? DATA_W'(v - step_of(s)) : DATA_W'(v + step_of(s));
    endfunction

endpackage

// File: rtl/updn_step_classifier.sv
// Combinational delta classifier: maps a modular delta onto {legal, direction, step code}.
module updn_step_classifier
    import up_down_pkg::*;
(
    input  logic [DATA_W-1:0] i_delta,
    output logic              o_legal,
    output logic              o_dir,
    output logic [SEL_W-1:0]  o_sel
);

    always_comb begin
        o_legal = 1'b0;
        o_dir   = 1'b0;
        o_sel   = '0;
        case (i_delta)
            8'h01: begin o_legal = 1'b1; o_dir = 1'b0; o_sel = 2'd0; end
            8'h02: begin o_legal = 1'b1; o_dir = 1'b0; o_sel = 2'd1; end
            8'h04: begin o_legal = 1'b1; o_dir = 1'b0; o_sel = 2'd2; end
            8'h08: begin o_legal = 1'b1; o_dir = 1'b0; o_sel = 2'd3; end
            8'hFF: begin o_legal = 1'b1; o_dir = 1'b1; o_sel = 2'd0; end
            8'hFE: begin o_legal = 1'b1; o_dir = 1'b1; o_sel = 2'd1; end
            8'hFC: begin o_legal = 1'b1; o_dir = 1'b1; o_sel = 2'd2; end
            8'hF8: begin o_legal = 1'b1; o_dir = 1'b1; o_sel = 2'd3; end
            default: ;
        endcase
    end

endmodule

// File: rtl/up_down_sequence_decoder.sv
// Recovers direction/step of an 8-bit counter stream, predicts the next value, flags breaks.
// Optional saturating error counter enabled by defining UPDN_DEC_ERR_CNT_EN.
module up_down_sequence_decoder
    import up_down_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 3
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] y,
    input  logic              comp,
    output logic              locked,
    output logic              up_down,
    output logic [SEL_W-1:0]  sel,
    output logic              err,
    output logic [DATA_W-1:0] expected,
    output logic [CNT_W-1:0]  err_count
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_ref;
    logic [RUN_W-1:0]    r_run;
    logic                r_cand_dir;
    logic [SEL_W-1:0]    r_cand_sel;
    logic                r_locked;
    logic                r_up_down;
    logic [SEL_W-1:0]    r_sel;
    logic                r_err;
    logic [DATA_W-1:0]   r_expected;

    logic [DATA_W-1:0]   w_v;
    logic [DATA_W-1:0]   w_delta;
    logic                w_hold;
    logic                w_legal;
    logic                w_dir;
    logic [SEL_W-1:0]    w_sel;
    logic                w_match;
    logic [RUN_W-1:0]    w_run_nxt;
    logic                w_err_set;

    assign w_v     = comp ? ~y : y;
    assign w_delta = DATA_W'(w_v - r_ref);
    assign w_hold  = (w_delta == '0);

    updn_step_classifier u_cls (
        .i_delta (w_delta),
        .o_legal (w_legal),
        .o_dir   (w_dir),
        .o_sel   (w_sel)
    );

    // A step only extends the run when it repeats the current candidate.
    assign w_match   = (r_run != '0) && (w_dir == r_cand_dir) && (w_sel == r_cand_sel);
    assign w_run_nxt = w_match ? RUN_W'(r_run + RUN_W'(1)) : RUN_W'(1);

    assign w_err_set = in_valid && (r_state == ST_LOCKED) && !w_hold && (w_v != r_expected);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= ST_IDLE;
            r_ref      <= '0;
            r_run      <= '0;
            r_cand_dir <= 1'b0;
            r_cand_sel <= '0;
            r_locked   <= 1'b0;
            r_up_down  <= 1'b0;
            r_sel      <= '0;
            r_err      <= 1'b0;
            r_expected <= '0;
        end else begin
            r_err <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_ref   <= w_v;
                        r_run   <= '0;
                        r_state <= ST_ACQ;
                    end
                    ST_ACQ: begin
                        if (!w_hold) begin
                            r_ref <= w_v;
                            if (w_legal) begin
                                r_cand_dir <= w_dir;
                                r_cand_sel <= w_sel;
                                r_run      <= w_run_nxt;
                                if (w_run_nxt == RUN_W'(LOCK_CNT)) begin
                                    r_state    <= ST_LOCKED;
                                    r_locked   <= 1'b1;
                                    r_up_down  <= w_dir;
                                    r_sel      <= w_sel;
                                    r_expected <= next_of(w_v, w_dir, w_sel);
                                end
                            end else begin
                                r_run <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_hold) begin
                            r_ref <= w_v;
                            if (w_err_set) begin
                                r_err    <= 1'b1;
                                r_locked <= 1'b0;
                                r_run    <= '0;
                                r_state  <= ST_ACQ;
                            end else begin
                                r_expected <= next_of(w_v, r_up_down, r_sel);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef UPDN_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Counts on the same edge that raises err, so both appear together.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_err_count <= '0;
        end else if (w_err_set && (r_err_count != '1)) begin
            r_err_count <= CNT_W'(r_err_count + CNT_W'(1));
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign locked   = r_locked;
    assign up_down  = r_up_down;
    assign sel      = r_sel;
    assign err      = r_err;
    assign expected = r_expected;

endmodule

// File: tb/tb_up_down_sequence_decoder.sv
// Self-checking bench: directed scenarios plus randomized counter streams against a behavioural model.
module tb_up_down_sequence_decoder;

    localparam int LOCK_CNT = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  y;
    logic        comp;
    logic        locked;
    logic        up_down;
    logic [1:0]  sel;
    logic        err;
    logic [7:0]  expected;
    logic [15:0] err_count;

    int n_chk = 0;
    int n_bad = 0;

    // Behavioural model state
    int m_has_ref, m_ref, m_run, m_cdir, m_csel;
    int m_locked, m_ud, m_sel, m_err, m_exp, m_cnt;

    up_down_sequence_decoder #(.LOCK_CNT(LOCK_CNT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .y         (y),
        .comp      (comp),
        .locked    (locked),
        .up_down   (up_down),
        .sel       (sel),
        .err       (err),
        .expected  (expected),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: delta arithmetic mod 256, step = power of two 1..8 either direction.
    task automatic model(input bit rst, input bit vld, input int yy, input bit cc);
        int v, d, step;
        bit lg;
        int dr, sl;
        if (rst) begin
            m_has_ref = 0; m_ref = 0; m_run = 0; m_cdir = 0; m_csel = 0;
            m_locked = 0; m_ud = 0; m_sel = 0; m_err = 0; m_exp = 0; m_cnt = 0;
            return;
        end
        m_err = 0;
        if (!vld) return;
        v = cc ? ((~yy) & 255) : (yy & 255);
        if (m_has_ref == 0) begin
            m_has_ref = 1; m_ref = v; m_run = 0;
            return;
        end
        d = (v - m_ref) & 255;
        if (d == 0) return;
        m_ref = v;
        lg = 0; dr = 0; sl = 0;
        for (int k = 0; k < 4; k++) begin
            if (d == (1 << k))       begin lg = 1; dr = 0; sl = k; end
            if (d == 256 - (1 << k)) begin lg = 1; dr = 1; sl = k; end
        end
        if (m_locked != 0) begin
            if (v == m_exp) begin
                step = 1 << m_sel;
                m_exp = (m_ud != 0) ? ((v - step) & 255) : ((v + step) & 255);
            end else begin
                m_err = 1; m_locked = 0; m_run = 0;
`ifdef UPDN_DEC_ERR_CNT_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
        end else if (!lg) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && dr == m_cdir && sl == m_csel) m_run++;
            else m_run = 1;
            m_cdir = dr; m_csel = sl;
            if (m_run == LOCK_CNT) begin
                m_locked = 1; m_ud = dr; m_sel = sl;
                step = 1 << sl;
                m_exp = (dr != 0) ? ((v - step) & 255) : ((v + step) & 255);
            end
        end
    endtask

    task automatic step(input bit rst, input bit vld, input logic [7:0] yy, input bit cc);
        rst_n = rst; in_valid = vld; y = yy; comp = cc;
        @(posedge clk);
        model(rst, vld, int'(yy), cc);
        #1;
        chk("locked",    32'(locked),    32'(m_locked));
        chk("err",       32'(err),       32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        if (m_locked != 0) begin
            chk("up_down",  32'(up_down),  32'(m_ud));
            chk("sel",      32'(sel),      32'(m_sel));
            chk("expected", 32'(expected), 32'(m_exp));
        end
    endtask

    task automatic send(input logic [7:0] yy);
        step(1'b0, 1'b1, yy, 1'b0);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    int exp_cnt1;
    logic [7:0] gv;
    logic [7:0] ry;
    bit gc;
    int gdir, gsel, r;

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; y = 8'h00; comp = 1'b0;
        do_reset();
        do_reset();
        chk("rst_locked",   32'(locked),    32'd0);
        chk("rst_up_down",  32'(up_down),   32'd0);
        chk("rst_sel",      32'(sel),       32'd0);
        chk("rst_err",      32'(err),       32'd0);
        chk("rst_expected", 32'(expected),  32'h00);
        chk("rst_err_cnt",  32'(err_count), 32'd0);

        // Up, step 1
        send(8'h10); send(8'h11); send(8'h12);
        chk("tp1_not_yet", 32'(locked), 32'd0);
        send(8'h13);
        chk("tp1_locked", 32'(locked), 32'd1);
        chk("tp1_ud", 32'(up_down), 32'd0);
        chk("tp1_sel", 32'(sel), 32'd0);
        chk("tp1_exp", 32'(expected), 32'h14);

        // Down, step 4 across wrap
        do_reset();
        send(8'h06); send(8'h02); send(8'hFE); send(8'hFA);
        chk("tp2_locked", 32'(locked), 32'd1);
        chk("tp2_ud", 32'(up_down), 32'd1);
        chk("tp2_sel", 32'(sel), 32'd2);
        chk("tp2_exp", 32'(expected), 32'hF6);

        // Break while locked, then relock
        do_reset();
        send(8'h20); send(8'h22); send(8'h24); send(8'h26);
        chk("tp3_locked", 32'(locked), 32'd1);
        send(8'h30);
`ifdef UPDN_DEC_ERR_CNT_EN
        exp_cnt1 = 1;
`else
        exp_cnt1 = 0;
`endif
        chk("tp3_err", 32'(err), 32'd1);
        chk("tp3_unlock", 32'(locked), 32'd0);
        chk("tp3_cnt", 32'(err_count), 32'(exp_cnt1));
        send(8'h32);
        chk("tp3_err_pulse", 32'(err), 32'd0);
        send(8'h34);
        chk("tp3_acq", 32'(locked), 32'd0);
        send(8'h36);
        chk("tp3_relock", 32'(locked), 32'd1);
        chk("tp3_exp", 32'(expected), 32'h38);

        // Holds and gaps at up/step 8
        do_reset();
        send(8'h28); send(8'h30); send(8'h38); send(8'h40);
        chk("tp4_locked", 32'(locked), 32'd1);
        chk("tp4_sel", 32'(sel), 32'd3);
        send(8'h40); send(8'h40);
        for (int i = 0; i < 5; i++) gap();
        send(8'h48);
        chk("tp4_err", 32'(err), 32'd0);
        chk("tp4_still", 32'(locked), 32'd1);
        chk("tp4_exp", 32'(expected), 32'h50);

        // Complemented stream
        do_reset();
        step(1'b0, 1'b1, 8'hFF, 1'b1); step(1'b0, 1'b1, 8'hFE, 1'b1);
        step(1'b0, 1'b1, 8'hFD, 1'b1); step(1'b0, 1'b1, 8'hFC, 1'b1);
        chk("tp5_locked", 32'(locked), 32'd1);
        chk("tp5_ud", 32'(up_down), 32'd0);
        chk("tp5_exp", 32'(expected), 32'h04);

        // Reset mid-lock
        do_reset();
        send(8'h10); send(8'h11); send(8'h12); send(8'h13);
        do_reset();
        chk("tp6_rst_locked", 32'(locked), 32'd0);
        chk("tp6_rst_exp", 32'(expected), 32'h00);
        chk("tp6_rst_cnt", 32'(err_count), 32'd0);
        send(8'h50); send(8'h51); send(8'h52);
        chk("tp6_three", 32'(locked), 32'd0);
        send(8'h53);
        chk("tp6_four", 32'(locked), 32'd1);

        // Randomized streams with holds, gaps, glitches, comp flips and resets
        do_reset();
        gv = 8'(($urandom) & 8'hFF); gc = 1'b0; gdir = 0; gsel = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 10) begin
                gap();
            end else if (r < 15) begin
                step(1'b0, 1'b1, gc ? ~gv : gv, gc);
            end else if (r < 18) begin
                ry = 8'(($urandom) & 8'hFF);
                gv = gc ? ~ry : ry;
                step(1'b0, 1'b1, ry, gc);
            end else if (r < 20) begin
                gc = ~gc;
                gv = ~gv;
                step(1'b0, 1'b1, gc ? ~gv : gv, gc);
            end else begin
                if (r < 24) begin
                    gdir = int'($urandom_range(0, 1));
                    gsel = int'($urandom_range(0, 3));
                end
                gv = (gdir != 0) ? 8'(gv - 8'(1 << gsel)) : 8'(gv + 8'(1 << gsel));
                step(1'b0, 1'b1, gc ? ~gv : gv, gc);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
